board_ram_arbiter: RTL

Shares the single-port board tile RAM between the board reload engine and the gameplay agents (Pac-Man mover, ghost movers, pellet/score logic). It sits between those requesters and the board RAM: it serialises accesses, gives reload strict priority, and locks out gameplay requesters while the game controller is in its reload state. One access is in flight at a time, and read data is returned to the requester that issued it.

---
 rtl/board_ram_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: serialises access to the single-port board tile RAM.
// Requester 0 (reload engine) has strict priority; while i_reload_mode is
// high only requester 0 is eligible. One access is in flight at a time.
// Optional feature macro: BOARD_ARB_RR_EN (round-robin among requesters
// 1..N_REQ-1). Without it, the lowest eligible index wins.
//
// Handshake: a requester raises i_req with i_we/i_addr/i_wdata stable and
// holds it until it sees its o_gnt bit (a one-cycle acceptance pulse); its
// fields are captured at the decision and may change freely afterwards.
// A read completes with a one-cycle o_rvalid pulse carrying o_rdata.
module board_ram_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_reload_mode,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ-1:0]         i_we,
    input  logic [N_REQ*ADDR_W-1:0]  i_addr,
    input  logic [N_REQ*DATA_W-1:0]  i_wdata,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [N_REQ-1:0]         o_rvalid,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_busy,
    output logic                     o_ram_en,
    output logic                     o_ram_we,
    output logic [ADDR_W-1:0]        o_ram_addr,
    output logic [DATA_W-1:0]        o_ram_wdata,
    input  logic [DATA_W-1:0]        i_ram_rdata,
    output logic [1:0]               o_dbg_state
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int IDX_W1 = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    win_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [N_REQ-1:0]    elig;
    logic                found;
    logic [IDX_W-1:0]    win_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

`ifdef BOARD_ARB_RR_EN
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W1-1:0]   cand_sum;
    logic [IDX_W-1:0]    cand_idx;
`endif

    // Arbitration: mask by reload mode, pick a winner, select its fields.
    always_comb begin
        elig    = i_req;
        found   = 1'b0;
        win_d   = '0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
`ifdef BOARD_ARB_RR_EN
        cand_sum = '0;
        cand_idx = '0;
`endif
        if (i_reload_mode) begin
            elig = {{(N_REQ-1){1'b0}}, i_req[0]};
        end
        if (elig[0]) begin
            found = 1'b1;
            win_d = '0;
        end else begin
`ifdef BOARD_ARB_RR_EN
            // Search starts at the pointer and wraps from N_REQ-1 back to 1.
            for (int i = 0; i < N_REQ - 1; i++) begin
                cand_sum = {1'b0, ptr_q} + IDX_W1'(i);
                if (cand_sum > IDX_W1'(N_REQ - 1)) begin
                    cand_sum = cand_sum - IDX_W1'(N_REQ - 1);
                end
                cand_idx = cand_sum[IDX_W-1:0];
                if (!found && elig[cand_idx]) begin
                    found = 1'b1;
                    win_d = cand_idx;
                end
            end
`else
            for (int i = 1; i < N_REQ; i++) begin
                if (!found && elig[i]) begin
                    found = 1'b1;
                    win_d = IDX_W'(i);
                end
            end
`endif
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (win_d == IDX_W'(k)) begin
                we_d    = i_we[k];
                addr_d  = i_addr[k*ADDR_W +: ADDR_W];
                wdata_d = i_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // State register and capture of the winning request at the IDLE decision.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && found) begin
                win_q   <= win_d;
                we_q    <= we_d;
                addr_q  <= addr_d;
                wdata_q <= wdata_d;
            end
        end
    end

`ifdef BOARD_ARB_RR_EN
    // Round-robin pointer: moves past a gameplay winner, untouched by reload.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= IDX_W'(1);
        end else if (state_q == S_IDLE && found && win_d != '0) begin
            if (win_d == IDX_W'(N_REQ - 1)) begin
                ptr_q <= IDX_W'(1);
            end else begin
                ptr_q <= win_d + IDX_W'(1);
            end
        end
    end
`endif

    // Next state: writes take two cycles, reads three.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = found ? S_ACCESS : S_IDLE;
            S_ACCESS: state_d = we_q ? S_IDLE : S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and the captured request.
    always_comb begin
        o_gnt       = '0;
        o_rvalid    = '0;
        o_rdata     = '0;
        o_ram_en    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        o_busy      = (state_q != S_IDLE);
        o_dbg_state = state_q;
        case (state_q)
            S_ACCESS: begin
                o_ram_en    = 1'b1;
                o_ram_we    = we_q;
                o_ram_addr  = addr_q;
                o_ram_wdata = wdata_q;
                for (int k = 0; k < N_REQ; k++) begin
                    if (win_q == IDX_W'(k)) o_gnt[k] = 1'b1;
                end
            end
            S_RESP: begin
                o_rdata = i_ram_rdata;
                for (int k = 0; k < N_REQ; k++) begin
                    if (win_q == IDX_W'(k)) o_rvalid[k] = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
